// File: rtl/fifo_wr_arbiter.sv
// Purpose: round-robin arbiter that lets four requesters write bursts into one shared FIFO.
// Latency: 1 cycle from req to the first gnt (IDLE picks the owner, BURST grants); owner/busy are registered.
// Backpressure: fifo_full=1 stalls the burst in place (no gnt, beat count and owner hold, no timeout).
//
// Ports:
//   clk, reset          - single clock, asynchronous active-high reset
//   req/last/wdata      - per-requester request, end-of-burst marker and DW-bit data slice
//   gnt                 - one-hot beat-accept strobe (combinational)
//   fifo_full/wr_en/din - shared FIFO write port
//   owner, busy         - registered burst owner index and BURST-state flag
//   stat_sel, stat_cnt  - per-requester accepted-beat counter readout
//
// Build option: define FIFO_WR_ARB_STATS_EN to build four saturating 8-bit beat
// counters; without it stat_cnt is tied to 0.
module fifo_wr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [3:0]      last,
  input  logic [4*DW-1:0] wdata,
  output logic [3:0]      gnt,
  input  logic            fifo_full,
  output logic            fifo_wr_en,
  output logic [DW-1:0]   fifo_din,
  output logic [1:0]      owner,
  output logic            busy,
  input  logic [1:0]      stat_sel,
  output logic [7:0]      stat_cnt
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  logic       state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;

  logic [1:0] pick;
  logic       pick_vld;
  logic       accept;
  logic [3:0] beat_cnt_inc;

  // Round-robin search: walk offsets from the highest down so the lowest
  // offset from rr_ptr (the first requester found going upward) wins.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[2'(rr_ptr_q + 2'(k))]) begin
        pick     = 2'(rr_ptr_q + 2'(k));
        pick_vld = 1'b1;
      end
    end
  end

  // A beat is written only while the owner still requests and the FIFO has room.
  assign accept       = (state_q == ST_BURST) && req[owner_q] && !fifo_full;
  assign beat_cnt_inc = beat_cnt_q + 4'd1;

  assign gnt        = accept ? (4'b0001 << owner_q) : 4'b0000;
  assign fifo_wr_en = accept;
  // Gated so the write bus reads 0 whenever nothing is being written (including reset).
  assign fifo_din   = accept ? wdata[DW*owner_q +: DW] : '0;

  assign owner = owner_q;
  assign busy  = (state_q == ST_BURST);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        beat_cnt_d = 4'd0;
        owner_d    = pick_vld ? pick : 2'd0;
        if (pick_vld) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!req[owner_q]) begin
          // Owner withdrew: close the tenure without writing anything.
          state_d  = ST_IDLE;
          rr_ptr_d = owner_q + 2'd1;
          owner_d  = 2'd0;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_inc;
          if (last[owner_q] || (beat_cnt_inc == 4'(MAX_BURST))) begin
            state_d  = ST_IDLE;
            rr_ptr_d = owner_q + 2'd1;
            owner_d  = 2'd0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      owner_q    <= 2'd0;
      beat_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [3:0][7:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i] && (stat_q[i] != 8'hff)) begin
        stat_d[i] = stat_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = stat_q[stat_sel];
`else
  logic [1:0] unused_stat_sel;
  assign unused_stat_sel = stat_sel;
  assign stat_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req, last, gnt;
  logic [4*DW-1:0] wdata;
  logic            fifo_full, fifo_wr_en, busy;
  logic [DW-1:0]   fifo_din;
  logic [1:0]      owner, stat_sel;
  logic [7:0]      stat_cnt;
  logic [23:0]     obs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .wdata(wdata),
    .gnt(gnt), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_din(fifo_din), .owner(owner), .busy(busy),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  assign obs = {busy, owner, gnt, fifo_wr_en, fifo_din, stat_cnt};

  // Reference model: tenure-level description of the arbiter.
  bit          m_busy;
  int          m_owner, m_rr, m_beats;
  int          m_stat[4];
  logic [23:0] e_vec;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0;
    for (int i = 0; i < 4; i++) m_stat[i] = 0;
  endtask

  task automatic model_outputs();
    logic [3:0]    eg;
    logic [DW-1:0] ed;
    logic [7:0]    es;
    eg = 4'b0; ed = '0;
    if (m_busy && req[m_owner] && !fifo_full) begin
      eg[m_owner] = 1'b1;
      ed = wdata[DW*m_owner +: DW];
    end
`ifdef FIFO_WR_ARB_STATS_EN
    es = 8'(m_stat[stat_sel]);
`else
    es = 8'd0;
`endif
    e_vec = {m_busy, 2'(m_owner), eg, |eg, ed, es};
  endtask

  task automatic model_advance();
    if (!m_busy) begin
      if (req != 4'b0) begin
        int k = 0;
        while (!req[(m_rr + k) % 4]) k++;
        m_owner = (m_rr + k) % 4;
        m_busy  = 1;
        m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      m_rr = (m_owner + 1) % 4; m_owner = 0; m_busy = 0;
    end else if (!fifo_full) begin
      m_beats++;
      if (m_stat[m_owner] < 255) m_stat[m_owner]++;
      if (last[m_owner] || m_beats == MAX_BURST) begin
        m_rr = (m_owner + 1) % 4; m_owner = 0; m_busy = 0;
      end
    end
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0; last = 4'b0; fifo_full = 1'b0; stat_sel = 2'd0;
    wdata = 32'($urandom);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1; req = 4'b1111; last = 4'b1111; wdata = 32'hA5A5_5A5A;
    fifo_full = 1'b0; stat_sel = 2'd3;
    #3;
    checks++;
    if (obs !== 24'h0) begin
      failures++; $display("FAIL reset_async got=%h exp=%h", obs, 24'h0);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== 24'h0) begin
      failures++; $display("FAIL reset_held_edge got=%h exp=%h", obs, 24'h0);
    end
    reset = 1'b0;
    req = 4'b0;
    for (int c = 0; c < 2; c++) begin
      #1; model_outputs(); checks++;
      if (obs !== e_vec) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs, e_vec);
      end
      tick();
    end
  endtask

  task automatic test_single_burst();
    int beats = 0, first = -1;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req  = (beats < 3)  ? 4'b0001 : 4'b0000;
      last = (beats == 2) ? 4'b0001 : 4'b0000;
      #1; model_outputs(); checks++;
      if (obs !== e_vec) begin
        failures++; $display("FAIL single_burst cyc=%0d got=%h exp=%h", c, obs, e_vec);
      end
      if (gnt[0]) begin beats++; if (first < 0) first = c; end
      tick();
      if (beats > 0) wdata[DW-1:0] = DW'($urandom);
    end
    checks++;
    if (beats !== 3) begin failures++; $display("FAIL single_burst_beats got=%0d exp=3", beats); end
    checks++;
    if (first !== 1) begin failures++; $display("FAIL single_burst_latency got=%0d exp=1", first); end
  endtask

  task automatic test_round_robin();
    int   seq[$], cnts[$];
    logic prev_busy = 1'b0;
    do_reset();
    req = 4'b1111; last = 4'b0;
    for (int c = 0; c < 27; c++) begin
      if (c >= 25) req = 4'b0;
      #1; model_outputs(); checks++;
      if (obs !== e_vec) begin
        failures++; $display("FAIL round_robin cyc=%0d got=%h exp=%h", c, obs, e_vec);
      end
      if (busy && !prev_busy) begin seq.push_back(int'(owner)); cnts.push_back(0); end
      if (gnt != 4'b0 && cnts.size() > 0) cnts[cnts.size()-1]++;
      prev_busy = busy;
      tick();
      wdata = 32'($urandom);
    end
    checks++;
    if (seq.size() != 5) begin
      failures++; $display("FAIL rr_burst_count got=%0d exp=5", seq.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (seq[k] != k % 4 || cnts[k] != MAX_BURST) begin
          failures++;
          $display("FAIL rr_burst%0d owner=%0d beats=%0d exp owner=%0d beats=%0d",
                   k, seq[k], cnts[k], k % 4, MAX_BURST);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    int beats = 0, rises = 0;
    int stall = 0;
    logic prev_busy = 1'b0;
    do_reset();
    last = 4'b0;
    for (int c = 0; c < 16; c++) begin
      req       = (beats < 4) ? 4'b0100 : 4'b0000;
      fifo_full = (beats == 2 && stall < 5);
      #1; model_outputs(); checks++;
      if (obs !== e_vec) begin
        failures++; $display("FAIL full_stall cyc=%0d got=%h exp=%h", c, obs, e_vec);
      end
      if (fifo_full) stall++;
      if (gnt[2]) beats++;
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
      tick();
      wdata = 32'($urandom);
    end
    fifo_full = 1'b0;
    checks++;
    if (beats !== 4 || rises !== 1) begin
      failures++; $display("FAIL full_stall_total beats=%0d bursts=%0d exp beats=4 bursts=1", beats, rises);
    end
  endtask

  task automatic test_req_drop();
    int beats = 0;
    int seq[$];
    logic prev_busy = 1'b0;
    do_reset();
    last = 4'b0;
    for (int c = 0; c < 8; c++) begin
      req = (beats < 2) ? 4'b0010 : 4'b1001;
      #1; model_outputs(); checks++;
      if (obs !== e_vec) begin
        failures++; $display("FAIL req_drop cyc=%0d got=%h exp=%h", c, obs, e_vec);
      end
      if (gnt[1]) beats++;
      if (busy && !prev_busy) seq.push_back(int'(owner));
      prev_busy = busy;
      tick();
    end
    checks++;
    if (beats !== 2 || seq.size() < 2 || seq[1] != 3) begin
      failures++;
      $display("FAIL req_drop_next beats=%0d next_owner=%0d exp beats=2 next_owner=3",
               beats, (seq.size() > 1) ? seq[1] : -1);
    end
  endtask

  task automatic test_async_reset();
    bit got = 0;
    do_reset();
    req = 4'b0001; last = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin req = 4'b0011; last = 4'b0000; end
      #1; model_outputs(); checks++;
      if (obs !== e_vec) begin
        failures++; $display("FAIL async_pre cyc=%0d got=%h exp=%h", c, obs, e_vec);
      end
      tick();
    end
    // Now owner 1 is in BURST with a beat pending; pulse reset between edges.
    #1; model_outputs(); checks++;
    if (obs !== e_vec) begin
      failures++; $display("FAIL async_mid got=%h exp=%h", obs, e_vec);
    end
    #1; reset = 1'b1; #1;
    checks++;
    if ({busy, gnt, fifo_wr_en} !== 6'b0) begin
      failures++; $display("FAIL async_reset_drop got=%b exp=000000", {busy, gnt, fifo_wr_en});
    end
    model_reset();
    #1; reset = 1'b0;
    tick();
    for (int c = 0; c < 4 && !got; c++) begin
      #1; model_outputs(); checks++;
      if (obs !== e_vec) begin
        failures++; $display("FAIL async_post cyc=%0d got=%h exp=%h", c, obs, e_vec);
      end
      if (gnt != 4'b0) begin
        got = 1;
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL async_next_gnt got=%b exp=0001", gnt); end
      end
      tick();
    end
    checks++;
    if (!got) begin failures++; $display("FAIL async_no_gnt got=none exp=gnt0"); end
  endtask

  task automatic test_stats();
    int beats = 0;
    do_reset();
    last = 4'b0;
    for (int c = 0; c < 1000 && beats < 300; c++) begin
      req = 4'b1000;
      #1; model_outputs(); checks++;
      if (obs !== e_vec) begin
        failures++; $display("FAIL stats_run cyc=%0d got=%h exp=%h", c, obs, e_vec);
      end
      if (gnt[3]) beats++;
      tick();
    end
    req = 4'b0;
    tick(); tick();
    checks++;
    if (beats !== 300) begin failures++; $display("FAIL stats_beats got=%0d exp=300", beats); end
    for (int s = 0; s < 4; s++) begin
      logic [7:0] exp_cnt;
      stat_sel = 2'(s);
      #1;
`ifdef FIFO_WR_ARB_STATS_EN
      exp_cnt = (s == 3) ? 8'd255 : 8'd0;
`else
      exp_cnt = 8'd0;
`endif
      checks++;
      if (stat_cnt !== exp_cnt) begin
        failures++; $display("FAIL stats_sel%0d got=%0d exp=%0d", s, stat_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] g;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      #1; model_outputs(); checks++;
      if (obs !== e_vec) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, e_vec);
      end
      g = gnt;
      tick();
      for (int i = 0; i < 4; i++) begin
        if (g[i] || (!req[i] && $urandom_range(2) == 0)) begin
          req[i]              = 1'($urandom_range(1));
          wdata[DW*i +: DW]   = DW'($urandom);
          last[i]             = ($urandom_range(3) == 0);
        end else if (req[i] && $urandom_range(19) == 0) begin
          req[i] = 1'b0;
        end
      end
      fifo_full = ($urandom_range(3) == 0);
      stat_sel  = 2'($urandom_range(3));
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_req_drop();
    test_async_reset();
    test_stats();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter: DW, 8, data width of each requester beat and of the FIFO write port.
REQ-002 Parameter: MAX_BURST, 4, maximum beats per grant tenure (range 1..15).
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: req  in  4  per-requester write request, bit i = requester i.
REQ-006 Port: last  in  4  per-requester end-of-burst marker, qualified by the accepted beat.
REQ-007 Port: wdata  in  4*DW  requester i data at [DW*i+DW-1 : DW*i].
REQ-008 Port: gnt  out  4  one-hot beat-accept strobe; gnt[i]=1 means requester i's current beat is written this cycle.
REQ-009 Port: fifo_full  in  1  full flag from the shared 8-deep sync FIFO.
REQ-010 Port: fifo_wr_en  out  1  write enable to the FIFO.
REQ-011 Port: fifo_din  out  DW  write data to the FIFO.
REQ-012 Port: owner  out  2  index of the current burst owner (0 when idle).
REQ-013 Port: busy  out  1  high while in BURST.
REQ-014 Port: stat_sel  in  2  selects requester for stat_cnt.
REQ-015 Port: stat_cnt  out  8  accepted-beat count of requester stat_sel.

Function
REQ-016 FSM states IDLE and BURST; reset state IDLE.
REQ-017 IDLE: gnt=0, fifo_wr_en=0; if any req bit is high, the first set bit found searching from rr_ptr upward (mod 4) is latched into owner and the FSM enters BURST next cycle.
REQ-018 IDLE with req=0 stays in IDLE; arbitration latency from req to earliest gnt is exactly 1 cycle.
REQ-019 BURST: gnt[owner] = req[owner] & !fifo_full, all other gnt bits 0, combinational.
REQ-020 fifo_wr_en = |gnt; fifo_din = wdata slice of owner, combinational, valid whenever fifo_wr_en=1.
REQ-021 Each accepted beat increments a 4-bit beat_cnt; beat_cnt clears on entry to BURST.
REQ-022 Burst ends on the accepted beat with last[owner]=1, or on the accepted beat that makes beat_cnt equal MAX_BURST, whichever comes first.
REQ-023 Burst also ends, with no beat written, on any BURST cycle where req[owner]=0.
REQ-024 At burst end: rr_ptr <= owner+1 (mod 4), FSM -> IDLE; one IDLE cycle always separates bursts.
REQ-025 fifo_full=1 in BURST stalls: no gnt, beat_cnt and owner hold, no timeout.
REQ-026 Requesters hold req, wdata and last stable until gnt; the arbiter never accepts a beat while fifo_full=1.
REQ-027 owner and busy are registered; busy=1 exactly in BURST.

Reset
REQ-028 Reset asserted: FSM IDLE, rr_ptr=0, owner=0, beat_cnt=0, busy=0, gnt=0, fifo_wr_en=0, fifo_din=0, stat counters 0, taking effect without a clock edge.
REQ-029 Reset mid-burst abandons the burst; the beat pending at reset is not written.

Configuration
REQ-030 Macro FIFO_WR_ARB_STATS_EN defined: four 8-bit counters, counter i increments on each gnt[i], saturates at 255; stat_cnt = counter[stat_sel], combinational.
REQ-031 Macro FIFO_WR_ARB_STATS_EN undefined: no counters are built; stat_cnt is constant 0; all other behaviour identical.

Verification
REQ-032 Reset, then req=4'b0001, last[0] on 3rd beat, fifo_full=0 -> busy rises 1 cycle after req, 3 consecutive gnt[0], fifo_din matches wdata[7:0] each beat, then IDLE.
REQ-033 req=4'b1111 held, last=0 -> owners served 0,1,2,3,0 in order, each exactly 4 beats (MAX_BURST), one idle cycle between bursts.
REQ-034 Owner 2 in BURST, fifo_full=1 for 5 cycles mid-burst -> gnt=0 and fifo_wr_en=0 throughout, beat_cnt holds, burst resumes and totals 4 beats.
REQ-035 Owner 1 drops req after 2 beats -> burst ends with no write that cycle, next arbitration starts at requester 2.
REQ-036 Reset pulsed asynchronously (between edges) mid-burst -> busy, gnt, fifo_wr_en drop to 0 immediately; next grant goes to requester 0.
REQ-037 With FIFO_WR_ARB_STATS_EN, 300 accepted beats from requester 3 -> stat_sel=3 reads 255, others 0; without macro -> stat_cnt reads 0.
